// File: rtl/l1_miss_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arb_types
//   Shared types and constants for the L1 miss arbiter.
//   - arb_state_t : arbiter FSM states
//   - line_t      : one cache line
//   - LINE_BYTES / OFFSET_BITS : line geometry (32-byte lines)
// ---------------------------------------------------------------------------
package arb_types;

  localparam int LINE_W      = 256;
  localparam int LINE_BYTES  = 32;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } arb_state_t;

endpackage

// File: rtl/l1_miss_arbiter_fairness.sv
// ---------------------------------------------------------------------------
// arb_fairness
//   Grant decision for the L1 miss arbiter. Dcache wins by default, but once
//   it has taken MAX_D_STREAK consecutive grants while the icache was waiting,
//   the icache gets the next grant.
//
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   i_req   : icache has a pending line request
//   d_req   : dcache has a pending line request (read or write)
//   decide  : arbiter is idle and will act on the grant this cycle
//   grant_i : icache wins (combinational, valid while decide is high)
//   grant_d : dcache wins (combinational, valid while decide is high)
// ---------------------------------------------------------------------------
module arb_fairness #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic decide,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  // Dcache grants taken while the icache was waiting.
  logic [3:0] streak_reg;
  logic [3:0] streak_next;

  always_comb begin
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    streak_next = streak_reg;
    if (decide) begin
      if (d_req && (!i_req || (streak_reg < STREAK_MAX))) begin
        grant_d = 1'b1;
        // Only grants that made the icache wait count toward the streak;
        // an uncontended dcache grant leaves it unchanged.
        if (i_req && (streak_reg < STREAK_MAX)) begin
          streak_next = streak_reg + 4'd1;
        end
      end else if (i_req) begin
        grant_i     = 1'b1;
        streak_next = 4'd0;
      end else begin
        streak_next = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak_reg <= 4'd0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/l1_miss_arbiter.sv
// ---------------------------------------------------------------------------
// l1_miss_arbiter
//   Shares the single L2 line port between the icache and dcache miss
//   interfaces. One line transaction at a time; the grant is held until the
//   L2 responds, then the winner sees a one-cycle resp pulse.
//
//   clk, rst                    : clock / asynchronous active-low reset
//   i_mem_read, i_mem_address   : icache line read request (held until resp)
//   i_mem_rdata, i_mem_resp     : line and completion pulse to icache
//   d_mem_read, d_mem_write     : dcache read / writeback request
//   d_mem_address, d_mem_wdata  : dcache address and writeback line
//   d_mem_rdata, d_mem_resp     : line and completion pulse to dcache
//   l2_read, l2_write           : request to the shared cache (registered)
//   l2_address, l2_wdata        : registered address / write line to L2
//   l2_rdata, l2_resp           : shared-cache response (data valid with resp)
//   i_grant_cnt, d_grant_cnt    : grants per side since reset (wrapping)
// ---------------------------------------------------------------------------
module l1_miss_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt
);

  import arb_types::*;

  arb_state_t        state_reg,    state_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [LINE_W-1:0] wdata_reg,    wdata_next;
  logic              l2_read_reg,  l2_read_next;
  logic              l2_write_reg, l2_write_next;
  logic [LINE_W-1:0] i_rdata_reg,  i_rdata_next;
  logic [LINE_W-1:0] d_rdata_reg,  d_rdata_next;
  logic              i_resp_reg,   i_resp_next;
  logic              d_resp_reg,   d_resp_next;
  logic [31:0]       i_cnt_reg,    i_cnt_next;
  logic [31:0]       d_cnt_reg,    d_cnt_next;

  logic decide;
  logic grant_i;
  logic grant_d;

  assign decide = (state_reg == IDLE);

  arb_fairness #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_fairness (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_mem_read),
    .d_req  (d_mem_read | d_mem_write),
    .decide (decide),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    l2_read_next  = l2_read_reg;
    l2_write_next = l2_write_reg;
    i_rdata_next  = i_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    i_resp_next   = 1'b0;
    d_resp_next   = 1'b0;
    i_cnt_next    = i_cnt_reg;
    d_cnt_next    = d_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next    = SERVE_D;
          addr_next     = d_mem_address;
          wdata_next    = d_mem_wdata;
          // Read+write together is illegal; the writeback wins so dirty
          // data is never lost.
          l2_write_next = d_mem_write;
          l2_read_next  = ~d_mem_write;
          d_cnt_next    = d_cnt_reg + 32'd1;
        end else if (grant_i) begin
          state_next    = SERVE_I;
          addr_next     = i_mem_address;
          l2_write_next = 1'b0;
          l2_read_next  = 1'b1;
          i_cnt_next    = i_cnt_reg + 32'd1;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          state_next    = RESP;
          i_rdata_next  = l2_rdata;
          i_resp_next   = 1'b1;
          l2_read_next  = 1'b0;
          l2_write_next = 1'b0;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          state_next    = RESP;
          d_rdata_next  = l2_rdata;
          d_resp_next   = 1'b1;
          l2_read_next  = 1'b0;
          l2_write_next = 1'b0;
        end
      end
      RESP: begin
        // The requester drops its request on this edge, so going straight
        // back to IDLE cannot regrant the completed transaction.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      l2_read_reg  <= 1'b0;
      l2_write_reg <= 1'b0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      i_resp_reg   <= 1'b0;
      d_resp_reg   <= 1'b0;
      i_cnt_reg    <= 32'd0;
      d_cnt_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      l2_read_reg  <= l2_read_next;
      l2_write_reg <= l2_write_next;
      i_rdata_reg  <= i_rdata_next;
      d_rdata_reg  <= d_rdata_next;
      i_resp_reg   <= i_resp_next;
      d_resp_reg   <= d_resp_next;
      i_cnt_reg    <= i_cnt_next;
      d_cnt_reg    <= d_cnt_next;
    end
  end

  assign l2_read     = l2_read_reg;
  assign l2_write    = l2_write_reg;
  assign l2_address  = addr_reg;
  assign l2_wdata    = wdata_reg;
  assign i_mem_rdata = i_rdata_reg;
  assign i_mem_resp  = i_resp_reg;
  assign d_mem_rdata = d_rdata_reg;
  assign d_mem_resp  = d_resp_reg;
  assign i_grant_cnt = i_cnt_reg;
  assign d_grant_cnt = d_cnt_reg;

  // Protocol checks on the requesters and the shared cache; ignored by
  // synthesis.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(d_mem_read && d_mem_write))
        else $warning("l1_miss_arbiter: d_mem_read and d_mem_write both high, serving the write");
      assert (!(l2_resp && ((state_reg == IDLE) || (state_reg == RESP))))
        else $warning("l1_miss_arbiter: l2_resp with no transaction in flight, ignored");
      assert (!(i_mem_read && (i_mem_address[OFFSET_BITS-1:0] != '0)))
        else $warning("l1_miss_arbiter: icache address not line aligned");
    end
  end

endmodule

// File: tb/tb_l1_miss_arbiter.sv
module tb_l1_miss_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_read;
  logic [AW-1:0] i_mem_address;
  logic [LW-1:0] i_mem_rdata;
  logic          i_mem_resp;
  logic          d_mem_read;
  logic          d_mem_write;
  logic [AW-1:0] d_mem_address;
  logic [LW-1:0] d_mem_wdata;
  logic [LW-1:0] d_mem_rdata;
  logic          d_mem_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;
  logic [31:0]   i_grant_cnt;
  logic [31:0]   d_grant_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_miss_arbiter #(
    .LINE_W(LW),
    .ADDR_W(AW),
    .MAX_D_STREAK(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_mem_read   (i_mem_read),
    .i_mem_address(i_mem_address),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_resp   (i_mem_resp),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_resp   (d_mem_resp),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_w1;
  logic [LW-1:0] pat_w2;
  logic [LW-1:0] pat_w3;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w1 = {8{32'hDEADBEEF}};
    pat_w2 = {8{32'h0BADF00D}};
    pat_w3 = {8{32'h12345678}};

    rst           = 1'b0;
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    l2_rdata      = '0;
    l2_resp       = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick(); tick();
    check("rst_l2_read",  l2_read, 0);
    check("rst_l2_write", l2_write, 0);
    check("rst_i_rdata",  i_mem_rdata, 0);
    check("rst_d_resp",   d_mem_resp, 0);
    check("rst_d_cnt",    d_grant_cnt, 0);
    rst = 1'b1;
    tick();

    // ---------------- 1: reset mid-transaction ----------------
    d_mem_write   = 1'b1;
    d_mem_address = 32'h200;
    d_mem_wdata   = pat_w1;
    tick();
    check("t1_l2_write_before", l2_write, 1);
    check("t1_d_cnt_before",    d_grant_cnt, 1);
    rst = 1'b0;
    #1;
    check("t1_l2_write_async", l2_write, 0);
    check("t1_l2_addr_async",  l2_address, 0);
    check("t1_l2_wdata_async", l2_wdata, 0);
    check("t1_d_cnt_async",    d_grant_cnt, 0);
    d_mem_write = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check("t1_idle_read",  l2_read, 0);
    check("t1_idle_write", l2_write, 0);
    check("t1_idle_i_cnt", i_grant_cnt, 0);
    $display("txn reset-abort d_write addr=00000200");

    // ---------------- 2: lone icache read ----------------
    i_mem_read    = 1'b1;
    i_mem_address = 32'h60;
    tick();
    check("t2_l2_read", l2_read, 1);
    check("t2_l2_addr", l2_address, 32'h60);
    check("t2_i_cnt",   i_grant_cnt, 1);
    l2_rdata = pat_a5;
    l2_resp  = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t2_i_resp",      i_mem_resp, 1);
    check("t2_i_rdata",     i_mem_rdata, pat_a5);
    check("t2_l2_read_drop", l2_read, 0);
    i_mem_read = 1'b0;
    tick();
    check("t2_i_resp_pulse", i_mem_resp, 0);
    check("t2_i_rdata_hold", i_mem_rdata, pat_a5);
    $display("txn i_read addr=00000060 rdata=%h", i_mem_rdata);
    tick();

    // ---------------- 3: simultaneous i read and d write ----------------
    i_mem_read    = 1'b1;
    i_mem_address = 32'h100;
    d_mem_write   = 1'b1;
    d_mem_address = 32'h200;
    d_mem_wdata   = pat_w1;
    tick();
    check("t3_d_first_write", l2_write, 1);
    check("t3_d_first_read",  l2_read, 0);
    check("t3_d_first_addr",  l2_address, 32'h200);
    check("t3_d_first_wdata", l2_wdata, pat_w1);
    l2_rdata = '0;
    l2_resp  = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t3_d_resp",        d_mem_resp, 1);
    check("t3_i_resp_quiet",  i_mem_resp, 0);
    d_mem_write = 1'b0;
    $display("txn d_write addr=00000200 wdata=%h", pat_w1);
    tick();
    check("t3_gap_d_resp", d_mem_resp, 0);
    tick();
    check("t3_i_next_read", l2_read, 1);
    check("t3_i_next_addr", l2_address, 32'h100);
    l2_rdata = pat_w3;
    l2_resp  = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t3_i_resp",       i_mem_resp, 1);
    check("t3_d_resp_quiet", d_mem_resp, 0);
    check("t3_i_rdata",      i_mem_rdata, pat_w3);
    i_mem_read = 1'b0;
    $display("txn i_read addr=00000100 rdata=%h", i_mem_rdata);
    tick();

    // ---------------- 4: starvation bound ----------------
    // Counters entering: i=2, d=1.
    i_mem_read    = 1'b1;
    i_mem_address = 32'h40;
    d_mem_read    = 1'b1;
    d_mem_address = 32'h80;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_d_grant_addr", l2_address, 32'h80 + k * 32);
      check("t4_d_grant_read", l2_read, 1);
      l2_rdata = LW'(k + 1);
      l2_resp  = 1'b1;
      tick();
      l2_resp = 1'b0;
      check("t4_d_resp",       d_mem_resp, 1);
      check("t4_d_rdata",      d_mem_rdata, LW'(k + 1));
      check("t4_i_resp_quiet", i_mem_resp, 0);
      $display("txn d_read addr=%h streak_step=%0d", 32'h80 + k * 32, k + 1);
      d_mem_address = 32'h80 + (k + 1) * 32;
      tick();
    end
    tick();
    check("t4_i_grant_addr", l2_address, 32'h40);
    check("t4_i_grant_read", l2_read, 1);
    check("t4_switch_d_cnt", d_grant_cnt, 5);
    check("t4_switch_i_cnt", i_grant_cnt, 3);
    l2_rdata = pat_a5;
    l2_resp  = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t4_i_resp", i_mem_resp, 1);
    i_mem_read = 1'b0;
    $display("txn i_read addr=00000040 after d streak");
    tick();
    tick();
    check("t4_d_resume_addr", l2_address, 32'h100);
    check("t4_d_resume_cnt",  d_grant_cnt, 6);
    l2_resp = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t4_d_resume_resp", d_mem_resp, 1);
    d_mem_read = 1'b0;
    $display("txn d_read addr=00000100 resumed");
    tick();

    // ---------------- 5: held-input stability ----------------
    d_mem_read    = 1'b1;
    d_mem_address = 32'h200;
    tick();
    check("t5_addr_grant", l2_address, 32'h200);
    d_mem_address = 32'h300;
    d_mem_wdata   = pat_w2;
    tick();
    check("t5_addr_hold1", l2_address, 32'h200);
    tick();
    check("t5_addr_hold2", l2_address, 32'h200);
    check("t5_read_hold",  l2_read, 1);
    l2_rdata = pat_w3;
    l2_resp  = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t5_d_resp",    d_mem_resp, 1);
    check("t5_d_rdata",   d_mem_rdata, pat_w3);
    check("t5_read_drop", l2_read, 0);
    d_mem_read = 1'b0;
    $display("txn d_read addr=00000200 rdata=%h", d_mem_rdata);
    tick();

    // ---------------- 6: illegal read+write ----------------
    d_mem_read    = 1'b1;
    d_mem_write   = 1'b1;
    d_mem_address = 32'h400;
    d_mem_wdata   = pat_w2;
    tick();
    check("t6_write",  l2_write, 1);
    check("t6_read",   l2_read, 0);
    check("t6_wdata",  l2_wdata, pat_w2);
    check("t6_d_cnt",  d_grant_cnt, 8);
    l2_resp = 1'b1;
    tick();
    l2_resp = 1'b0;
    check("t6_d_resp", d_mem_resp, 1);
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    $display("txn d_read+write addr=00000400 served as write");
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_single_pulse", d_mem_resp, 0);
      check("t6_no_regrant",   l2_write, 0);
    end
    check("t6_final_d_cnt", d_grant_cnt, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
